// File: rtl/gate_link_pkg.sv
// rtl/gate_link_pkg.sv - shared types, line levels and parity helper for the gate transmit stage
package gate_link_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Even parity bit over a zero-extended word (words up to 64 bits)
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/gate_tx_serializer_if.sv
// rtl/gate_tx_serializer_if.sv - data-source / sequencer handshake bundle for one gate
interface gate_tx_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_full;
  logic              i_tx_start;
  logic              o_tx_ready;
  logic              o_tx_line;
  logic              o_busy;
  logic              o_underrun;

  modport master (
    output i_data, i_valid, i_tx_start,
    input  o_full, o_tx_ready, o_tx_line, o_busy, o_underrun
  );

  modport slave (
    input  i_data, i_valid, i_tx_start,
    output o_full, o_tx_ready, o_tx_line, o_busy, o_underrun
  );
endinterface

// File: rtl/gate_tx_fifo.sv
// rtl/gate_tx_fifo.sv - small synchronous word FIFO feeding the serializer
module gate_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_dout  = mem_q[rd_q];

  // Writes while full and reads while empty are silently ignored
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  // Pointer and occupancy next-state; pointers wrap because DEPTH is a power of two
  always_comb begin
    wr_d  = do_push ? wr_q + AW'(1) : wr_q;
    rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  // Pointer and occupancy registers; reset empties the buffer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array, no reset needed since occupancy gates every read
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q] <= i_din;
  end

endmodule

// File: rtl/gate_tx_serializer.sv
// rtl/gate_tx_serializer.sv - per-gate buffered framed serializer with start/parity/stop bits
module gate_tx_serializer #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  gate_tx_serializer_if.slave  bus
);
  import gate_link_pkg::*;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              line_q, line_d;
  logic              busy_q;
  logic              underrun_q;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty;
  logic              is_idle, start_ok, div_last;

  assign is_idle  = (state_q == IDLE);
  assign start_ok = bus.i_tx_start && is_idle && !fifo_empty;
  assign div_last = (div_q == DIV_LAST);

  gate_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (bus.i_valid),
    .i_pop   (start_ok),
    .i_din   (bus.i_data),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign bus.o_full     = fifo_full;
  assign bus.o_tx_ready = is_idle && !fifo_empty;
  assign bus.o_tx_line  = line_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_underrun = underrun_q;

  // Frame sequencing: line_d always carries the level of the bit entered next cycle
  always_comb begin
    state_d  = state_q;
    div_d    = is_idle ? '0 : (div_last ? '0 : div_q + DIV_W'(1));
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    line_d   = line_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start_ok) begin
          state_d  = START;
          shift_d  = fifo_dout;
          parity_d = even_parity(64'(fifo_dout));
          line_d   = START_BIT;
        end
      end
      START: if (div_last) begin
        state_d = DATA;
        idx_d   = '0;
        line_d  = shift_q[0];
      end
      DATA: if (div_last) begin
        if (idx_q == IDX_LAST) begin
          state_d = PARITY;
          idx_d   = '0;
          line_d  = parity_q;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          shift_d = shift_q >> 1;
          line_d  = shift_d[0];
        end
      end
      PARITY: if (div_last) begin
        state_d = STOP;
        line_d  = STOP_BIT;
      end
      STOP: if (div_last) begin
        state_d = IDLE;
        line_d  = LINE_IDLE;
      end
      default: begin
        state_d = IDLE;
        line_d  = LINE_IDLE;
      end
    endcase
  end

  // Serializer state; reset aborts any frame and returns the line high at once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      line_q     <= LINE_IDLE;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      line_q     <= line_d;
      busy_q     <= (state_d != IDLE);
      underrun_q <= bus.i_tx_start && is_idle && fifo_empty;
    end
  end

endmodule

// File: tb/tb_gate_tx_serializer.sv
// tb/tb_gate_tx_serializer.sv - randomized and directed checks of gate_tx_serializer against a frame-level model
module tb_gate_tx_serializer;
  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int FL      = (DATA_W + 3) * CLK_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_tx_serializer_if #(.DATA_W(DATA_W)) bus ();

  gate_tx_serializer #(
    .DATA_W     (DATA_W),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Model: queue of pending words plus elapsed cycles of the frame on the line
  logic [DATA_W-1:0] mq[$];
  int                m_t = -1;
  logic [DATA_W+2:0] m_frame = '1;
  logic              m_under = 1'b0;
  logic [DATA_W-1:0] m_w;
  int                m_sz;
  bit                m_busy;

  always @(negedge rst_n) begin
    mq.delete();
    m_t     = -1;
    m_under = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_busy  = (m_t >= 0);
      m_sz    = mq.size();
      m_under = bus.i_tx_start && !m_busy && (m_sz == 0);
      if (m_busy) begin
        m_t++;
        if (m_t == FL) m_t = -1;
      end
      if (bus.i_tx_start && !m_busy && m_sz > 0) begin
        m_w     = mq.pop_front();
        m_frame = {1'b1, ^m_w, m_w, 1'b0};
        m_t     = 0;
      end
      if (bus.i_valid && m_sz < DEPTH) mq.push_back(bus.i_data);
    end
  end

  logic [4:0] exp_o, act_o;
  always @(negedge clk) begin
    if (cmp_en) begin
      exp_o = {(m_t < 0) ? 1'b1 : m_frame[m_t / CLK_DIV], (m_t >= 0),
               (m_t < 0) && (mq.size() > 0), (mq.size() == DEPTH), m_under};
      act_o = {bus.o_tx_line, bus.o_busy, bus.o_tx_ready, bus.o_full, bus.o_underrun};
      n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL model t=%0t line/busy/ready/full/underrun got %b want %b", $time, act_o, exp_o);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.i_tx_start = 1'b1;
    tick();
    bus.i_tx_start = 1'b0;
  endtask

  task automatic wait_ready(input int max);
    int n = 0;
    while (!bus.o_tx_ready && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_tx_ready) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (bus.o_busy && n < max) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_busy) chk("wait_idle_timeout", 1, 0);
  endtask

  // Sample each bit mid-period, starting on the cycle right after the start edge
  task automatic capture(output logic [DATA_W+2:0] f);
    f = '0;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      if (i % CLK_DIV == CLK_DIV / 2) f[i / CLK_DIV] = bus.o_tx_line;
    end
  endtask

  logic [DATA_W+2:0] fr;
  logic [10:0]       pat;
  logic [7:0]        words [4];
  int                busy_cnt;

  initial begin
    bus.i_valid    = 1'b0;
    bus.i_data     = '0;
    bus.i_tx_start = 1'b0;
    cmp_en         = 1'b1;

    // 1 reset state and quiet hold after release
    repeat (3) @(negedge clk);
    chk("rst_line", bus.o_tx_line, 1);
    chk("rst_ready", bus.o_tx_ready, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_full", bus.o_full, 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("hold_line", bus.o_tx_line, 1);
    chk("hold_ready", bus.o_tx_ready, 0);

    // 2 single frame of 8'hA5, every cycle against the literal bit pattern
    pat = 11'b10_1010_0101_0;
    push(8'hA5);
    pulse_start();
    busy_cnt = 0;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      if (bus.o_tx_line !== pat[i / CLK_DIV]) chk($sformatf("a5_bit_cyc%0d", i), bus.o_tx_line, pat[i / CLK_DIV]);
      else n_cmp++;
      if (bus.o_busy) busy_cnt++;
    end
    @(negedge clk);
    chk("a5_busy_cycles", busy_cnt, 44);
    chk("a5_busy_after", bus.o_busy, 0);
    chk("a5_ready_after", bus.o_tx_ready, 0);

    // 3 fill, overflow drop, drain in order
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h3C; words[3] = 8'hF0;
    tick();
    for (int k = 0; k < 4; k++) push(words[k]);
    chk("full_after_4", bus.o_full, 1);
    push(8'h99);
    chk("full_after_drop", bus.o_full, 1);
    for (int k = 0; k < 4; k++) begin
      wait_ready(FL + 4);
      pulse_start();
      if (k == 0) chk("full_after_pop", bus.o_full, 0);
      capture(fr);
      chk($sformatf("order_w%0d", k), fr, {1'b1, ^words[k], words[k], 1'b0});
    end
    wait_idle(8);
    @(negedge clk);
    chk("drop_not_sent_ready", bus.o_tx_ready, 0);

    // 4 underrun pulse, then start mid-frame ignored
    tick();
    pulse_start();
    @(negedge clk);
    chk("underrun_pulse", bus.o_underrun, 1);
    chk("underrun_line", bus.o_tx_line, 1);
    @(negedge clk);
    chk("underrun_one_cycle", bus.o_underrun, 0);
    tick();
    push(8'h5A);
    wait_ready(4);
    pulse_start();
    repeat (10) tick();
    pulse_start();
    @(negedge clk);
    chk("midframe_no_underrun", bus.o_underrun, 0);
    chk("midframe_busy", bus.o_busy, 1);
    wait_idle(FL + 4);

    // 5 push and start together with two words queued
    tick();
    push(8'h31);
    push(8'h32);
    wait_ready(4);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h33;
    pulse_start();
    bus.i_valid = 1'b0;
    capture(fr);
    chk("same_cycle_oldest", fr, {1'b1, 1'b1, 8'h31, 1'b0});
    wait_ready(FL);
    pulse_start();
    capture(fr);
    chk("same_cycle_second", fr, {1'b1, 1'b1, 8'h32, 1'b0});
    wait_ready(FL);
    pulse_start();
    capture(fr);
    chk("same_cycle_pushed", fr, {1'b1, 1'b0, 8'h33, 1'b0});
    wait_idle(8);

    // 6 reset during DATA bit 3, then a clean frame
    tick();
    push(8'h77);
    push(8'h0F);
    wait_ready(4);
    pulse_start();
    repeat (17) @(negedge clk);
    chk("pre_reset_line", bus.o_tx_line, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_line_now", bus.o_tx_line, 1);
    chk("reset_busy_now", bus.o_busy, 0);
    chk("reset_ready_now", bus.o_tx_ready, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_fifo_empty", bus.o_tx_ready, 0);
    tick();
    push(8'hC3);
    wait_ready(4);
    pulse_start();
    capture(fr);
    chk("post_reset_frame", fr, {1'b1, 1'b0, 8'hC3, 1'b0});

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.i_valid    = ($urandom_range(0, 2) == 0);
      bus.i_data     = 8'($urandom);
      bus.i_tx_start = ($urandom_range(0, 9) == 0);
      tick();
    end
    bus.i_valid    = 1'b0;
    bus.i_tx_start = 1'b0;
    wait_idle(FL + 4);
    repeat (2) @(negedge clk);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
